mem_bus_arbiter: RTL and testbench

Shares the single 16-bit system memory bus between the CPU port and a DMA port. It arbitrates each bus cycle and drives address, data and strobes onto the shared bus. It generates the active-low RAM/ROM/IO chip selects from the standard memory map and inserts per-region wait states. It sits between the requesters and the memory/IO devices, taking over sequencing that the combinational address decode alone cannot provide.

---
 rtl/mem_bus_arbiter_if.sv | 13 +
 rtl/mem_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side port of the memory bus arbiter: one request/ack handshake.
// The requester drives the master modport; the arbiter uses the slave modport.
interface mem_bus_arbiter_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        ack;
    logic [7:0]  rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin CPU/DMA arbiter for the shared 16-bit memory bus.
// Generates registered chip selects, strobes and per-region wait states.
module mem_bus_arbiter #(
    parameter int RAM_WAIT = 0,
    parameter int IO_WAIT  = 1,
    parameter int ROM_WAIT = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    mem_bus_arbiter_if.slave        cpu,
    mem_bus_arbiter_if.slave        dma,
    output logic [15:0]             bus_addr,
    output logic [7:0]              bus_wdata,
    input  logic [7:0]              bus_rdata,
    output logic                    bus_we,
    output logic                    bus_re,
    output logic                    ram_sel_n,
    output logic                    io_sel_n,
    output logic                    rom_sel_n,
    output logic                    rom_wr_err
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    localparam logic [1:0] REG_RAM = 2'd0;
    localparam logic [1:0] REG_IO  = 2'd1;
    localparam logic [1:0] REG_ROM = 2'd2;

    logic [1:0]  state;
    logic [7:0]  wait_cnt;
    logic        owner_dma;
    logic        last_grant_dma;
    logic        xfer_we;
    logic [1:0]  xfer_region;
    logic        cpu_ack_q;
    logic        dma_ack_q;
    logic [7:0]  cpu_rdata_q;
    logic [7:0]  dma_rdata_q;

    logic        grant_any;
    logic        grant_dma;
    logic        grant_we;
    logic [15:0] grant_addr;
    logic [7:0]  grant_wdata;
    logic [1:0]  grant_region;
    logic [7:0]  grant_wait;

    function automatic logic [1:0] region_of(input logic [15:0] addr);
        if (addr[15:13] == 3'b111) return REG_ROM;
        if (addr[15:12] == 4'hD)   return REG_IO;
        return REG_RAM;
    endfunction

    // Both requesting: serve whichever port did not win the previous cycle.
    always_comb begin
        // NOTE: every output gets a value before any branch, so no latch is inferred.
        grant_wait   = 8'(RAM_WAIT);
        grant_any    = cpu.req | dma.req;
        grant_dma    = dma.req & (~cpu.req | ~last_grant_dma);
        grant_addr   = grant_dma ? dma.addr  : cpu.addr;
        grant_we     = grant_dma ? dma.we    : cpu.we;
        grant_wdata  = grant_dma ? dma.wdata : cpu.wdata;
        grant_region = region_of(grant_addr);
        case (grant_region)
            REG_IO:  grant_wait = 8'(IO_WAIT);
            REG_ROM: grant_wait = 8'(ROM_WAIT);
            default: grant_wait = 8'(RAM_WAIT);
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            owner_dma      <= 1'b0;
            last_grant_dma <= 1'b1;
            xfer_we        <= 1'b0;
            xfer_region    <= REG_RAM;
            cpu_ack_q      <= 1'b0;
            dma_ack_q      <= 1'b0;
            cpu_rdata_q    <= '0;
            dma_rdata_q    <= '0;
            bus_addr       <= '0;
            bus_wdata      <= '0;
            bus_we         <= 1'b0;
            bus_re         <= 1'b0;
            ram_sel_n      <= 1'b1;
            io_sel_n       <= 1'b1;
            rom_sel_n      <= 1'b1;
            rom_wr_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state       <= ACCESS;
                        owner_dma   <= grant_dma;
                        xfer_we     <= grant_we;
                        xfer_region <= grant_region;
                        wait_cnt    <= grant_wait;
                        bus_addr    <= grant_addr;
                        bus_wdata   <= grant_wdata;
                        // ROM is never written: select it but suppress the write strobe.
                        bus_we      <= grant_we && (grant_region != REG_ROM);
                        bus_re      <= ~grant_we;
                        ram_sel_n   <= (grant_region != REG_RAM);
                        io_sel_n    <= (grant_region != REG_IO);
                        rom_sel_n   <= (grant_region != REG_ROM);
                    end
                end
                ACCESS: begin
                    if (wait_cnt == 8'd0) begin
                        state          <= DONE;
                        bus_we         <= 1'b0;
                        bus_re         <= 1'b0;
                        ram_sel_n      <= 1'b1;
                        io_sel_n       <= 1'b1;
                        rom_sel_n      <= 1'b1;
                        last_grant_dma <= owner_dma;
                        rom_wr_err     <= xfer_we && (xfer_region == REG_ROM);
                        if (owner_dma) begin
                            dma_ack_q <= 1'b1;
                            if (!xfer_we) dma_rdata_q <= bus_rdata;
                        end else begin
                            cpu_ack_q <= 1'b1;
                            if (!xfer_we) cpu_rdata_q <= bus_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    cpu_ack_q  <= 1'b0;
                    dma_ack_q  <= 1'b0;
                    rom_wr_err <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    cpu_ack_q  <= 1'b0;
                    dma_ack_q  <= 1'b0;
                    rom_wr_err <= 1'b0;
                    bus_we     <= 1'b0;
                    bus_re     <= 1'b0;
                    ram_sel_n  <= 1'b1;
                    io_sel_n   <= 1'b1;
                    rom_sel_n  <= 1'b1;
                end
            endcase
        end
    end

    assign cpu.ack   = cpu_ack_q;
    assign cpu.rdata = cpu_rdata_q;
    assign dma.ack   = dma_ack_q;
    assign dma.rdata = dma_rdata_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: requesters push expected completions,
// a negedge monitor pops and checks them on every ack.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_we, bus_re;
    logic        ram_sel_n, io_sel_n, rom_sel_n;
    logic        rom_wr_err;

    mem_bus_arbiter_if cpu_if ();
    mem_bus_arbiter_if dma_if ();

    mem_bus_arbiter #(.RAM_WAIT(0), .IO_WAIT(1), .ROM_WAIT(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu        (cpu_if),
        .dma        (dma_if),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_we     (bus_we),
        .bus_re     (bus_re),
        .ram_sel_n  (ram_sel_n),
        .io_sel_n   (io_sel_n),
        .rom_sel_n  (rom_sel_n),
        .rom_wr_err (rom_wr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_dma;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        logic [2:0]  sel_n;   // {ram, io, rom} during ACCESS
        int          waits;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    function automatic logic [7:0] rd_model(input logic [15:0] a);
        if (a == 16'h1234) return 8'hA5;
        return a[15:8] ^ a[7:0];
    endfunction

    assign bus_rdata = rd_model(bus_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk_exp(input logic is_dma, input logic we, input logic [15:0] addr,
                                    input logic [7:0] wdata, input logic [7:0] rdata,
                                    input logic [2:0] sel_n, input int waits, input logic err);
        exp_t e;
        e.is_dma = is_dma; e.we = we; e.addr = addr; e.wdata = wdata;
        e.rdata = rdata; e.sel_n = sel_n; e.waits = waits; e.err = err;
        return e;
    endfunction

    // Reference memory map used for generated vectors (sweep and round-robin).
    function automatic exp_t model_exp(input logic is_dma, input logic we,
                                       input logic [15:0] addr, input logic [7:0] wdata);
        logic [3:0] nib;
        nib = addr[15:12];
        if (nib >= 4'hE)      return mk_exp(is_dma, we, addr, wdata, rd_model(addr), 3'b110, 2, we);
        else if (nib == 4'hD) return mk_exp(is_dma, we, addr, wdata, rd_model(addr), 3'b101, 1, 1'b0);
        else                  return mk_exp(is_dma, we, addr, wdata, rd_model(addr), 3'b011, 0, 1'b0);
    endfunction

    // Call at a negedge; returns at the negedge where ack was seen, with req already dropped.
    task automatic do_xfer(input logic is_dma, input logic we, input logic [15:0] addr,
                           input logic [7:0] wdata);
        logic got;
        got = 1'b0;
        if (is_dma) begin
            dma_if.req = 1'b1; dma_if.we = we; dma_if.addr = addr; dma_if.wdata = wdata;
        end else begin
            cpu_if.req = 1'b1; cpu_if.we = we; cpu_if.addr = addr; cpu_if.wdata = wdata;
        end
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = is_dma ? dma_if.ack : cpu_if.ack;
        end
        if (is_dma) dma_if.req = 1'b0;
        else        cpu_if.req = 1'b0;
        check(is_dma ? "dma_ack_timeout" : "cpu_ack_timeout", got, 1'b1);
    endtask

    always @(posedge clk) cyc++;

    // Monitor state
    int         acc_cnt = 0;
    logic [2:0] acc_sel = 3'b111;
    logic [15:0] acc_addr = '0;
    logic [7:0] acc_wdata = '0;
    logic       seen_we = 1'b0, seen_re = 1'b0;
    logic [7:0] mdl_rd_cpu = '0, mdl_rd_dma = '0;
    logic       rr_phase = 1'b0;
    int         last_ack_cyc = -1;
    logic [2:0] sel_now;
    exp_t       mon_e;

    always @(negedge clk) begin
        sel_now = {ram_sel_n, io_sel_n, rom_sel_n};
        if (!reset_n) begin
            acc_cnt = 0; acc_sel = 3'b111; seen_we = 1'b0; seen_re = 1'b0;
            mdl_rd_cpu = '0; mdl_rd_dma = '0;
        end else begin
            check("at_most_one_select", $countones(~sel_now) <= 1, 1'b1);
            check("strobe_outside_access", (bus_we | bus_re) && (sel_now == 3'b111), 1'b0);
            if (sel_now != 3'b111) begin
                acc_cnt++;
                acc_sel   = sel_now;
                acc_addr  = bus_addr;
                acc_wdata = bus_wdata;
                seen_we   = seen_we | bus_we;
                seen_re   = seen_re | bus_re;
            end
            if (cpu_if.ack || dma_if.ack) begin
                check("dual_ack", cpu_if.ack & dma_if.ack, 1'b0);
                check("ack_expected", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    check("ack_port", dma_if.ack, mon_e.is_dma);
                    check("select_pattern", acc_sel, mon_e.sel_n);
                    check("access_cycles", acc_cnt, 1 + mon_e.waits);
                    check("selects_high_in_ack", sel_now, 3'b111);
                    check("bus_addr", acc_addr, mon_e.addr);
                    check("bus_addr_hold", bus_addr, mon_e.addr);
                    if (mon_e.we) check("bus_wdata", acc_wdata, mon_e.wdata);
                    check("bus_we_strobe", seen_we, mon_e.we && !mon_e.err);
                    check("bus_re_strobe", seen_re, !mon_e.we);
                    check("rom_wr_err", rom_wr_err, mon_e.err);
                    if (!mon_e.we) begin
                        if (mon_e.is_dma) mdl_rd_dma = mon_e.rdata;
                        else              mdl_rd_cpu = mon_e.rdata;
                    end
                    check("cpu_rdata", cpu_if.rdata, mdl_rd_cpu);
                    check("dma_rdata", dma_if.rdata, mdl_rd_dma);
                    if (rr_phase && last_ack_cyc >= 0) check("ack_spacing", cyc - last_ack_cyc, 3);
                    last_ack_cyc = cyc;
                end
                acc_cnt = 0; acc_sel = 3'b111; seen_we = 1'b0; seen_re = 1'b0;
            end else begin
                check("err_without_ack", rom_wr_err, 1'b0);
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
        dma_if.req = 1'b0; dma_if.we = 1'b0; dma_if.addr = '0; dma_if.wdata = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_bus_addr", bus_addr, 16'h0000);
        check("rst_bus_wdata", bus_wdata, 8'h00);
        check("rst_selects", {ram_sel_n, io_sel_n, rom_sel_n}, 3'b111);
        check("rst_strobes", {bus_we, bus_re}, 2'b00);
        check("rst_acks", {cpu_if.ack, dma_if.ack, rom_wr_err}, 3'b000);
        check("rst_rdata", {cpu_if.rdata, dma_if.rdata}, 16'h0000);
        #1 reset_n = 1'b1;
        @(negedge clk);

        // CPU read from RAM
        sb_q.push_back(mk_exp(1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5, 3'b011, 0, 1'b0));
        do_xfer(1'b0, 1'b0, 16'h1234, 8'h00);
        repeat (3) @(negedge clk);

        // DMA write to IO
        sb_q.push_back(mk_exp(1'b1, 1'b1, 16'hD010, 8'h3C, 8'h00, 3'b101, 1, 1'b0));
        do_xfer(1'b1, 1'b1, 16'hD010, 8'h3C);
        repeat (3) @(negedge clk);

        // CPU read from ROM, then an illegal ROM write
        sb_q.push_back(mk_exp(1'b0, 1'b0, 16'hFFFC, 8'h00, 8'h03, 3'b110, 2, 1'b0));
        do_xfer(1'b0, 1'b0, 16'hFFFC, 8'h00);
        repeat (2) @(negedge clk);
        sb_q.push_back(mk_exp(1'b0, 1'b1, 16'hE000, 8'h77, 8'h00, 3'b110, 2, 1'b1));
        do_xfer(1'b0, 1'b1, 16'hE000, 8'h77);
        repeat (3) @(negedge clk);

        // Continuous contention from reset: CPU wins first, then strict alternation
        apply_reset();
        rr_phase = 1'b1;
        last_ack_cyc = -1;
        for (int i = 0; i < 10; i++) begin
            sb_q.push_back(model_exp(1'b0, 1'((i % 2) == 1), 16'h0100 + 16'(i * 16), 8'(8'h10 + i)));
            sb_q.push_back(model_exp(1'b1, 1'((i % 2) == 0), 16'h8000 + 16'(i * 4),  8'(8'h80 + i)));
        end
        fork
            begin
                for (int i = 0; i < 10; i++)
                    do_xfer(1'b0, 1'((i % 2) == 1), 16'h0100 + 16'(i * 16), 8'(8'h10 + i));
            end
            begin
                for (int j = 0; j < 10; j++)
                    do_xfer(1'b1, 1'((j % 2) == 0), 16'h8000 + 16'(j * 4), 8'(8'h80 + j));
            end
        join
        rr_phase = 1'b0;
        repeat (3) @(negedge clk);

        // Address sweep across the memory map
        for (int i = 0; i < 16; i++) begin
            sb_q.push_back(model_exp(1'b0, 1'b0, 16'(i << 12), 8'h00));
            do_xfer(1'b0, 1'b0, 16'(i << 12), 8'h00);
            @(negedge clk);
        end
        repeat (2) @(negedge clk);

        // Reset during the second ROM ACCESS cycle
        cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 16'hE010; cpu_if.wdata = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1 check("rom_sel_mid_access", rom_sel_n, 1'b0);
        #1 reset_n = 1'b0;
        cpu_if.req = 1'b0;
        #1;
        check("abort_selects", {ram_sel_n, io_sel_n, rom_sel_n}, 3'b111);
        check("abort_strobes", {bus_we, bus_re}, 2'b00);
        check("abort_acks", {cpu_if.ack, dma_if.ack}, 2'b00);
        check("abort_rdata", cpu_if.rdata, 8'h00);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        sb_q.push_back(mk_exp(1'b0, 1'b0, 16'h0040, 8'h00, 8'h40, 3'b011, 0, 1'b0));
        do_xfer(1'b0, 1'b0, 16'h0040, 8'h00);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
